ks_decomp: RTL and testbench
============================

# ks_decomp

Keyswitch decomposer for the HPU. It sits between sample extraction, whose output is blind-rotation LWE coefficients on 64 bits, and the keyswitch multiply-accumulate stage, whose consumer multiplies each digit by a KSK coefficient. For every incoming 64-bit coefficient it rounds to the KS_L·KS_B_W most significant bits and emits KS_L balanced signed digits serially, one level per cycle, under valid/ready flow control.

## Interface
- MOD_Q_W, 64, coefficient width.
- KS_L, 8, number of decomposition levels.
- KS_B_W, 2, decomposition base width; base B = 2^KS_B_W.
- DIG_W, KS_B_W+1, signed digit width.
- LVL_W, $clog2(KS_L), level index width.

Ports:
- clk  in  1  clock.
- a_rst  in  1  reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- in_coef  in  MOD_Q_W  coefficient, unsigned mod 2^MOD_Q_W.
- in_last  in  1  last coefficient of the ciphertext (body).
- in_vld  in  1  input valid.
- in_rdy  out  1  input ready.
- out_digit  out  DIG_W  signed digit, two's complement.
- out_lvl  out  LVL_W  level index; 0 is the least significant digit.
- out_coef_last  out  1  out_lvl == KS_L-1.
- out_ct_last  out  1  out_coef_last and the coefficient carried in_last.
- out_vld  out  1  output valid.
- out_rdy  in  1  output ready.
- busy  out  1  a coefficient is held in the stage.

## Operation
**Rounding, at acceptance.** Let S = MOD_Q_W − KS_L·KS_B_W (48 with the defaults).
- Compute r = ((in_coef + 2^(S−1)) mod 2^MOD_Q_W) >> S, which is KS_L·KS_B_W bits wide.
- Ties round up. Wrap-around of the addition is intentional.

**Decomposition, one digit per level, LSB first.**
- Start with c = 0.
- For level j: d = r[j·KS_B_W +: KS_B_W] + c.
- If d ≥ B/2, emit d − B and set c = 1. Otherwise emit d and set c = 0.
- Digit range is [−B/2, B/2−1], which is [−2, 1] with the defaults.
- The carry out of level KS_L−1 is discarded (mod q).

**State machine.**
- IDLE: no coefficient held.
  - in_rdy = 1, out_vld = 0.
  - On in_vld, latch r, in_last, lvl = 0, c = 0, and go to EMIT.
- EMIT: out_vld = 1.
  - The digit is computed combinationally from the held r, lvl and c.
  - On out_vld & out_rdy with lvl < KS_L−1: increment lvl and update c.
  - On out_vld & out_rdy with lvl = KS_L−1: if in_vld, latch the next coefficient and stay in EMIT with lvl = 0. Otherwise go to IDLE.
- in_rdy = IDLE | (EMIT & out_rdy & lvl == KS_L−1). This gives zero-bubble back-to-back coefficients.
- Outputs are held stable while out_vld & ~out_rdy.
- busy = (state == EMIT).

## Timing
- Reset values: state IDLE, in_rdy = 0 while a_rst is asserted and 1 after, out_vld = 0, out_digit = 0, out_lvl = 0, out_coef_last = 0, out_ct_last = 0, busy = 0. The held r, c and last flag are all cleared.
- Latency: a coefficient accepted at cycle t shows level 0 valid at t+1.
- Throughput: one coefficient per KS_L cycles when out_rdy is held high.
- Reset mid-operation: the held coefficient is dropped. No partial digits are emitted after reset release.
- Simultaneous events: last-level handshake together with in_vld hands over in the same cycle; the next coefficient's level 0 appears the following cycle.
- in_vld while EMIT and not at the last-level handshake: in_rdy = 0, so the input is not taken.

## Test plan
- in_coef = 0 → eight digits of 0, out_lvl counts 0..7, out_coef_last only on level 7.
- in_coef = 3·2^48 → digits [−1, 1, 0, 0, 0, 0, 0, 0]; with in_last = 1, out_ct_last is asserted on level 7.
- in_coef = 2^47 → r = 1 (tie rounds up) → digits [1, 0, …, 0]. in_coef = 2^64−1 → wraps to r = 0 → all digits 0.
- in_coef = 2^63 → r = 0x8000 → levels 0–6 are 0, level 7 is −2, carry dropped. in_coef = 0x5555·2^48 → alternating digits [1, 1, …] checked against a reference model, including reconstruction Σ d_j·4^j ≡ r mod 2^16.
- 1000 random coefficients with random out_rdy and in_vld gaps → digit stream matches the model. Outputs are stable under stall, there are no drops or duplicates, and full-throughput bursts show no bubbles.
- Assert a_rst at level 4 of a coefficient → out_vld = 0 and busy = 0 immediately. After release, a new coefficient starts at level 0 with c = 0.

Source files
------------

// File: rtl/ks_decomp.sv
// Keyswitch decomposer: rounds each 64-bit LWE coefficient to its top KS_L*KS_B_W bits and
// streams KS_L balanced signed base-2^KS_B_W digits, least significant level first.
// Latency: a coefficient accepted at cycle t presents level 0 at t+1. Throughput is one
// coefficient per KS_L cycles.
// Backpressure: outputs hold while out_vld & ~out_rdy. in_rdy is high only when the stage is
// empty, or when the last level is being handed off in the same cycle (zero-bubble handover).
//
// Ports:
//   clk, a_rst           clock; asynchronous active-high reset
//   in_coef/in_last      coefficient and "last coefficient of ciphertext" flag
//   in_vld/in_rdy        input handshake
//   out_digit            signed digit, two's complement, DIG_W bits
//   out_lvl              level index, 0 = least significant digit
//   out_coef_last        high on level KS_L-1
//   out_ct_last          high on level KS_L-1 of a coefficient that carried in_last
//   out_vld/out_rdy      output handshake
//   busy                 a coefficient is held in the stage
module ks_decomp #(
    parameter int MOD_Q_W = 64,
    parameter int KS_L    = 8,
    parameter int KS_B_W  = 2,
    parameter int DIG_W   = KS_B_W + 1,
    parameter int LVL_W   = $clog2(KS_L)
) (
    input  logic               clk,
    input  logic               a_rst,
    input  logic [MOD_Q_W-1:0] in_coef,
    input  logic               in_last,
    input  logic               in_vld,
    output logic               in_rdy,
    output logic [DIG_W-1:0]   out_digit,
    output logic [LVL_W-1:0]   out_lvl,
    output logic               out_coef_last,
    output logic               out_ct_last,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic               busy
);

    // Width of the rounded value and the number of low bits discarded by rounding.
    localparam int R_W = KS_L * KS_B_W;
    localparam int S   = MOD_Q_W - R_W;

    localparam logic [MOD_Q_W-1:0] HALF     = MOD_Q_W'(1) << (S - 1);
    localparam logic [LVL_W-1:0]   LVL_LAST = LVL_W'(KS_L - 1);
    localparam logic [DIG_W-1:0]   BASE     = DIG_W'(1) << KS_B_W;
    localparam logic [DIG_W-1:0]   HALF_B   = DIG_W'(1) << (KS_B_W - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [R_W-1:0]   r_q, r_d;
    logic             c_q, c_d;
    logic             last_q, last_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;

    // ------------------------------------------------------------------
    // Rounding at acceptance. The addition wraps modulo 2^MOD_Q_W on
    // purpose: values just below 2^MOD_Q_W round to zero, as they do
    // on the torus.
    // ------------------------------------------------------------------
    logic [MOD_Q_W-1:0] rnd_sum;
    logic [R_W-1:0]     r_in;

    assign rnd_sum = in_coef + HALF;
    assign r_in    = rnd_sum[MOD_Q_W-1:S];

    // ------------------------------------------------------------------
    // Digit for the current level, from the held rounded value and the
    // carry left by the previous level. d ranges over 0..B, so one extra
    // bit above the slice is enough to hold it before re-centring.
    // ------------------------------------------------------------------
    logic [R_W-1:0]    r_shift;
    logic [KS_B_W-1:0] slice;
    logic [DIG_W-1:0]  d_raw;
    logic              carry;
    logic [DIG_W-1:0]  digit;

    always_comb begin
        r_shift = r_q >> (lvl_q * KS_B_W);
        slice   = r_shift[KS_B_W-1:0];
        d_raw   = DIG_W'(slice) + DIG_W'(c_q);
        carry   = (d_raw >= HALF_B);
        // d - B wraps naturally into the two's complement range [-B/2, B/2-1]
        digit   = carry ? (d_raw - BASE) : d_raw;
    end

    // ------------------------------------------------------------------
    // Handshake terms
    // ------------------------------------------------------------------
    logic emit;
    logic at_last;
    logic out_fire;
    logic in_fire;

    assign emit     = (state_q == ST_EMIT);
    assign at_last  = (lvl_q == LVL_LAST);
    assign out_fire = emit & out_rdy;
    assign in_fire  = in_vld & in_rdy;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_vld) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                // Stay in EMIT when the next coefficient is handed over on
                // the last-level handshake.
                if (out_fire && at_last && !in_vld) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        // in_rdy is forced low while reset is asserted so nothing is taken
        // by a stage that is about to be cleared.
        in_rdy        = ~a_rst & (~emit | (out_rdy & at_last));
        out_vld       = emit;
        busy          = emit;
        // Digit and flags are masked when idle so a stale held value never
        // shows up on the bus.
        out_digit     = emit ? digit : '0;
        out_lvl       = lvl_q;
        out_coef_last = emit & at_last;
        out_ct_last   = emit & at_last & last_q;
    end

    // ------------------------------------------------------------------
    // Held coefficient, level counter and carry
    // ------------------------------------------------------------------
    always_comb begin
        r_d    = r_q;
        c_d    = c_q;
        last_d = last_q;
        lvl_d  = lvl_q;
        if (in_fire) begin
            // Covers both the idle load and the last-level handover.
            r_d    = r_in;
            last_d = in_last;
            lvl_d  = '0;
            c_d    = 1'b0;
        end else if (out_fire) begin
            if (at_last) begin
                // Final carry is dropped: reduction mod q.
                lvl_d = '0;
                c_d   = 1'b0;
            end else begin
                lvl_d = lvl_q + LVL_W'(1);
                c_d   = carry;
            end
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            r_q    <= '0;
            c_q    <= 1'b0;
            last_q <= 1'b0;
            lvl_q  <= '0;
        end else begin
            r_q    <= r_d;
            c_q    <= c_d;
            last_q <= last_d;
            lvl_q  <= lvl_d;
        end
    end

endmodule

// File: tb/tb_ks_decomp.sv
// Testbench for ks_decomp: directed vectors, randomized traffic with stalls and gaps,
// mid-operation reset and a full-throughput burst, all against an arithmetic reference.
module tb_ks_decomp;

    logic        clk = 1'b0;
    logic        a_rst;
    logic [63:0] in_coef;
    logic        in_last;
    logic        in_vld;
    logic        in_rdy;
    logic [2:0]  out_digit;
    logic [2:0]  out_lvl;
    logic        out_coef_last;
    logic        out_ct_last;
    logic        out_vld;
    logic        out_rdy;
    logic        busy;

    always #5 clk = ~clk;

    ks_decomp dut (
        .clk          (clk),
        .a_rst        (a_rst),
        .in_coef      (in_coef),
        .in_last      (in_last),
        .in_vld       (in_vld),
        .in_rdy       (in_rdy),
        .out_digit    (out_digit),
        .out_lvl      (out_lvl),
        .out_coef_last(out_coef_last),
        .out_ct_last  (out_ct_last),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .busy         (busy)
    );

    typedef struct packed {
        logic [2:0] dig;
        logic [2:0] lvl;
        logic       cl;
        logic       ctl;
    } exp_t;

    exp_t exp_q[$];   // digits still owed by the DUT, in order
    int   obs[$];     // every digit the DUT handed off, as signed ints

    int n_chk   = 0;
    int n_err   = 0;
    int n_ticks = 0;
    int rdy_pct = 100;
    logic acc;

    logic       stall_prev = 1'b0;
    logic [2:0] st_dig, st_lvl;
    logic       st_cl, st_ctl;

    // Hand-derived digits for the directed vectors, LSB level first.
    int dir_tab [48] = '{
        0, 0, 0, 0, 0, 0, 0, 0,     // 0
        -1, 1, 0, 0, 0, 0, 0, 0,    // 3*2^48 -> r=3
        1, 0, 0, 0, 0, 0, 0, 0,     // 2^47 -> r=1 (tie up)
        0, 0, 0, 0, 0, 0, 0, 0,     // 2^64-1 -> wraps to r=0
        0, 0, 0, 0, 0, 0, 0, -2,    // 2^63 -> r=0x8000
        1, 1, 1, 1, 1, 1, 1, 1      // 0x5555*2^48
    };

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: round by adding half of the dropped range (mod 2^64), keep the
    // top 16 bits, then peel base-4 digits re-centred into [-2, 1].
    function automatic void model_push(input logic [63:0] coef, input logic last);
        logic [63:0] s;
        int r, c, d;
        exp_t e;
        s = coef + 64'h0000_8000_0000_0000;
        r = int'(s >> 48);
        c = 0;
        for (int j = 0; j < 8; j++) begin
            d = ((r >> (2 * j)) & 3) + c;
            if (d >= 2) begin
                d = d - 4;
                c = 1;
            end else begin
                c = 0;
            end
            e.dig = 3'(d);
            e.lvl = 3'(j);
            e.cl  = (j == 7);
            e.ctl = (j == 7) && last;
            exp_q.push_back(e);
        end
    endfunction

    // One clock: drive at negedge, observe 1 time unit later, account the
    // handshakes that the coming posedge will commit.
    task automatic tick(input logic vld, input logic [63:0] coef, input logic last, input logic ordy);
        exp_t e;
        @(negedge clk);
        in_vld  = vld;
        in_coef = coef;
        in_last = last;
        out_rdy = ordy;
        #1;
        n_ticks++;
        if (n_ticks > 60000) begin
            $display("FAIL watchdog ticks=%0d limit=60000", n_ticks);
            $fatal(1, "cycle budget exhausted");
        end
        check("out_vld", out_vld, exp_q.size() != 0);
        check("busy", busy, exp_q.size() != 0);
        check("in_rdy", in_rdy, (exp_q.size() == 0) || (exp_q.size() == 1 && ordy));
        if (stall_prev) begin
            check("stall_vld", out_vld, 1);
            check("stall_dig", out_digit, st_dig);
            check("stall_lvl", out_lvl, st_lvl);
            check("stall_cl", out_coef_last, st_cl);
            check("stall_ctl", out_ct_last, st_ctl);
        end
        if (out_vld && exp_q.size() != 0) begin
            e = exp_q[0];
            check("digit", out_digit, e.dig);
            check("lvl", out_lvl, e.lvl);
            check("coef_last", out_coef_last, e.cl);
            check("ct_last", out_ct_last, e.ctl);
        end
        if (out_vld && ordy) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            obs.push_back(int'($signed(out_digit)));
        end
        acc = vld && in_rdy;
        if (acc) model_push(coef, last);
        stall_prev = out_vld && !ordy;
        st_dig = out_digit;
        st_lvl = out_lvl;
        st_cl  = out_coef_last;
        st_ctl = out_ct_last;
    endtask

    task automatic send(input logic [63:0] coef, input logic last);
        int tries;
        tries = 0;
        do begin
            tick(1'b1, coef, last, $urandom_range(99) < rdy_pct);
            tries++;
        end while (!acc && tries < 200);
        check("send_accepted", acc, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick(1'b0, 64'd0, 1'b0, $urandom_range(99) < rdy_pct);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        longint sum;
        int     t0;
        int     gaps;
        logic [63:0] coef;

        a_rst   = 1'b1;
        in_vld  = 1'b0;
        in_coef = 64'd0;
        in_last = 1'b0;
        out_rdy = 1'b0;
        #1;
        check("rst_in_rdy", in_rdy, 0);
        check("rst_out_vld", out_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_digit", out_digit, 0);
        check("rst_lvl", out_lvl, 0);
        check("rst_coef_last", out_coef_last, 0);
        check("rst_ct_last", out_ct_last, 0);
        repeat (3) @(negedge clk);
        a_rst = 1'b0;
        #1;
        check("rel_in_rdy", in_rdy, 1);
        check("rel_out_vld", out_vld, 0);

        // Directed vectors, back to back at full rate.
        rdy_pct = 100;
        send(64'h0000_0000_0000_0000, 1'b0);
        send(64'h0003_0000_0000_0000, 1'b1);
        send(64'h0000_8000_0000_0000, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send(64'h8000_0000_0000_0000, 1'b0);
        send(64'h5555_0000_0000_0000, 1'b0);
        drain();
        check("dir_count", obs.size(), 48);
        for (int i = 0; i < 48; i++) begin
            check($sformatf("dir_dig%0d", i), (i < obs.size()) ? obs[i] : 99, dir_tab[i]);
        end
        sum = 0;
        for (int j = 0; j < 8; j++) begin
            if (40 + j < obs.size()) sum += longint'(obs[40 + j]) * (longint'(1) << (2 * j));
        end
        check("recon_5555", ((sum % 65536) + 65536) % 65536, 16'h5555);

        // Reset in the middle of a coefficient whose carry is set at level 4.
        send(64'hFFFF_0000_0000_0000, 1'b1);
        for (int k = 0; k < 20 && exp_q.size() > 4; k++) tick(1'b0, 64'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("pre_rst_lvl", out_lvl, 4);
        a_rst = 1'b1;
        #1;
        check("midrst_out_vld", out_vld, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_rdy", in_rdy, 0);
        exp_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        a_rst = 1'b0;
        send(64'h0000_0000_0000_0000, 1'b0);
        drain();

        // Random traffic with output stalls and input gaps.
        rdy_pct = 75;
        for (int i = 0; i < 1000; i++) begin
            gaps = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(3));
            for (int g = 0; g < gaps; g++)
                tick(1'b0, {$urandom, $urandom}, 1'($urandom_range(1)), $urandom_range(99) < rdy_pct);
            case ($urandom_range(7))
                0:       coef = {16'($urandom), 48'h7FFF_FFFF_FFFF};
                1:       coef = {16'($urandom), 48'h8000_0000_0000};
                default: coef = {$urandom, $urandom};
            endcase
            send(coef, 1'($urandom_range(1)));
        end
        drain();

        // Full-throughput burst: 20 coefficients must take 20*8 cycles plus
        // the initial acceptance cycle, with no bubbles.
        rdy_pct = 100;
        t0 = n_ticks;
        for (int i = 0; i < 20; i++) send({$urandom, $urandom}, 1'($urandom_range(1)));
        drain();
        check("burst_cycles", n_ticks - t0, 161);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
